// File: rtl/avalon_mem_arbiter.sv
// Avalon-MM master that arbitrates NUM_PORTS CPU-side requesters onto one memory bus,
// one transaction at a time, with an optional waitrequest timeout and registered responses.
module avalon_mem_arbiter #(
  parameter  int ADDR_W         = 32,
  parameter  int DATA_W         = 32,
  parameter  int NUM_PORTS      = 2,
  parameter  int ARB_MODE       = 0,
  parameter  int TIMEOUT_CYCLES = 0,
  localparam int BE_W           = DATA_W / 8,
  localparam int ID_W           = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        is_reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  input  logic [NUM_PORTS*BE_W-1:0]   req_byteenable,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic                        rsp_err,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        busy,
  output logic [ID_W-1:0]             grant_id,
  output logic [ADDR_W-1:0]           address,
  output logic                        read,
  output logic                        write,
  output logic [DATA_W-1:0]           writedata,
  output logic [BE_W-1:0]             byteenable,
  input  logic                        waitrequest,
  input  logic [DATA_W-1:0]           readdata
);

  localparam int                TO_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BE_W - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t              state, state_next;
  logic [ID_W-1:0]     rr_ptr;
  logic [TO_W-1:0]     to_cnt;
  logic [TO_W-1:0]     to_cnt_inc;
  logic                timeout_hit;

  logic                found;
  logic [ID_W-1:0]     win;
  logic                win_write;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic [BE_W-1:0]     win_be;

  assign to_cnt_inc  = to_cnt + TO_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt_inc == TO_W'(TIMEOUT_CYCLES));

  // Pass 0 only considers ports at or after the round-robin pointer; pass 1 wraps around.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    win_write = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_be    = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!found && req[i] && (pass == 1 || ARB_MODE == 0 || ID_W'(i) >= rr_ptr)) begin
          found     = 1'b1;
          win       = ID_W'(i);
          win_write = req_write[i];
          win_addr  = req_addr[i*ADDR_W +: ADDR_W];
          win_wdata = req_wdata[i*DATA_W +: DATA_W];
          win_be    = req_byteenable[i*BE_W +: BE_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge is_reset) begin
    if (is_reset) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = BUS;
      BUS:     if (!waitrequest || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The read/write strobes double as the latched operation type while in BUS.
  always_ff @(posedge clk or posedge is_reset) begin
    if (is_reset) begin
      rsp_valid  <= '0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      rr_ptr     <= '0;
      to_cnt     <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (found) begin
            busy       <= 1'b1;
            grant_id   <= win;
            address    <= win_addr & ALIGN_MASK;
            writedata  <= win_wdata;
            byteenable <= win_be;
            read       <= !win_write;
            write      <= win_write;
          end
        end
        BUS: begin
          if (!waitrequest) begin
            read      <= 1'b0;
            write     <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= read ? readdata : '0;
          end else begin
            to_cnt <= to_cnt_inc;
            if (timeout_hit) begin
              read      <= 1'b0;
              write     <= 1'b0;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        RESP: begin
          rsp_valid <= NUM_PORTS'(1) << grant_id;
          busy      <= 1'b0;
          to_cnt    <= '0;
          if (ARB_MODE == 1)
            rr_ptr <= (grant_id == ID_W'(NUM_PORTS - 1)) ? '0 : grant_id + ID_W'(1);
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Scoreboard bench: a round-robin/timeout instance (A) and a fixed-priority instance (B)
// share the bus stub; expected responses are queued by stimulus and popped by monitors.
module tb_avalon_mem_arbiter;

  typedef struct {
    int          port;
    bit          err;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk = 1'b0;
  logic        is_reset;
  logic [1:0]  reqA, reqB, reqWrite;
  logic [63:0] reqAddr, reqWdata;
  logic [7:0]  reqBe;
  logic        waitrequest;
  logic [31:0] readdata;

  logic [1:0]  rspValidA, rspValidB;
  logic        rspErrA, rspErrB, busyA, busyB, readA, readB, writeA, writeB;
  logic [31:0] rspRdataA, rspRdataB, addressA, addressB, writedataA, writedataB;
  logic [0:0]  grantIdA, grantIdB;
  logic [3:0]  byteenableA, byteenableB;

  rsp_t expQA[$];
  rsp_t expQB[$];
  rsp_t popA, popB;
  int   compared = 0;
  int   mismatched = 0;

  avalon_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .NUM_PORTS(2), .ARB_MODE(1), .TIMEOUT_CYCLES(4)) dutA (
    .clk(clk), .is_reset(is_reset), .req(reqA), .req_write(reqWrite), .req_addr(reqAddr),
    .req_wdata(reqWdata), .req_byteenable(reqBe), .rsp_valid(rspValidA), .rsp_err(rspErrA),
    .rsp_rdata(rspRdataA), .busy(busyA), .grant_id(grantIdA), .address(addressA), .read(readA),
    .write(writeA), .writedata(writedataA), .byteenable(byteenableA), .waitrequest(waitrequest),
    .readdata(readdata)
  );

  avalon_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .NUM_PORTS(2), .ARB_MODE(0), .TIMEOUT_CYCLES(4)) dutB (
    .clk(clk), .is_reset(is_reset), .req(reqB), .req_write(reqWrite), .req_addr(reqAddr),
    .req_wdata(reqWdata), .req_byteenable(reqBe), .rsp_valid(rspValidB), .rsp_err(rspErrB),
    .rsp_rdata(rspRdataB), .busy(busyB), .grant_id(grantIdB), .address(addressB), .read(readB),
    .write(writeB), .writedata(writedataB), .byteenable(byteenableB), .waitrequest(waitrequest),
    .readdata(readdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Response monitors: every rsp_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rspValidA != 2'b00) begin
      if (expQA.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedRspA: got rsp_valid 0x%0h, expected no response", rspValidA);
      end else begin
        popA = expQA.pop_front();
        checkOutput("rspPortA", 64'(rspValidA), 64'(1) << popA.port);
        checkOutput("rspErrA", 64'(rspErrA), 64'(popA.err));
        checkOutput("rspRdataA", 64'(rspRdataA), 64'(popA.rdata));
      end
    end
  end

  always @(negedge clk) begin
    if (rspValidB != 2'b00) begin
      if (expQB.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedRspB: got rsp_valid 0x%0h, expected no response", rspValidB);
      end else begin
        popB = expQB.pop_front();
        checkOutput("rspPortB", 64'(rspValidB), 64'(1) << popB.port);
        checkOutput("rspErrB", 64'(rspErrB), 64'(popB.err));
        checkOutput("rspRdataB", 64'(rspRdataB), 64'(popB.rdata));
      end
    end
  end

  // One transaction on instance A; entered and left on a negedge with A idle.
  task automatic applyStimulus(input int port, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be, input int nwait,
                               input logic [31:0] rdata, input bit expErr);
    int stall;
    stall = expErr ? 3 : nwait;
    reqA = 2'b00;
    reqA[port] = 1'b1;
    reqWrite[port] = wr;
    reqAddr[port*32 +: 32] = addr;
    reqWdata[port*32 +: 32] = wdata;
    reqBe[port*4 +: 4] = be;
    waitrequest = expErr || (nwait > 0);
    readdata = rdata;
    expQA.push_back('{port: port, err: expErr, rdata: (wr || expErr) ? 32'h0 : rdata});
    for (int k = 0; k <= stall; k++) begin
      @(negedge clk);
      checkOutput("strobeRead", 64'(readA), 64'(!wr));
      checkOutput("strobeWrite", 64'(writeA), 64'(wr));
      checkOutput("writedata", 64'(writedataA), 64'(wdata));
      checkOutput("byteenable", 64'(byteenableA), 64'(be));
      checkOutput("address", 64'(addressA), 64'({addr[31:2], 2'b00}));
      if (k == 0) begin
        checkOutput("grantId", 64'(grantIdA), 64'(port));
        checkOutput("busyBus", 64'(busyA), 64'd1);
        reqA = 2'b00;
      end
      if (!expErr && k == nwait) waitrequest = 1'b0;
    end
    @(negedge clk);
    checkOutput("strobesDropped", 64'({readA, writeA}), 64'd0);
    checkOutput("busyResp", 64'(busyA), 64'd1);
    checkOutput("noEarlyRsp", 64'(rspValidA), 64'd0);
    @(negedge clk);
    waitrequest = 1'b0;
    checkOutput("rspValidTiming", 64'(rspValidA), 64'(1) << port);
    checkOutput("busyIdle", 64'(busyA), 64'd0);
  endtask

  // Both ports request reads continuously for four grants (E0, E3, E6, E9).
  task automatic runContention(input bit useB, input bit expAlt);
    logic [1:0] rv;
    logic [0:0] gid;
    int         expPort;
    reqWrite = 2'b00;
    reqAddr = {32'h0000_7004, 32'h0000_6000};
    reqBe = 8'hFF;
    waitrequest = 1'b0;
    readdata = useB ? 32'hB0B0_1111 : 32'hA0A0_2222;
    for (int i = 0; i < 4; i++) begin
      if (useB) expQB.push_back('{port: 0, err: 1'b0, rdata: readdata});
      else      expQA.push_back('{port: expAlt ? (i % 2) : 0, err: 1'b0, rdata: readdata});
    end
    if (useB) reqB = 2'b11;
    else      reqA = 2'b11;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      rv  = useB ? rspValidB : rspValidA;
      gid = useB ? grantIdB : grantIdA;
      expPort = expAlt ? (((k - 1) / 3) % 2) : 0;
      if (k <= 12) begin
        checkOutput(useB ? "fixedGrantId" : "rrGrantId", 64'(gid), 64'(expPort));
        checkOutput(useB ? "fixedRspValid" : "rrRspValid", 64'(rv),
                    ((k - 1) % 3 == 2) ? (64'(1) << expPort) : 64'd0);
      end
      if (k == 10) begin
        reqA = 2'b00;
        reqB = 2'b00;
      end
    end
  endtask

  initial begin
    is_reset = 1'b1;
    reqA = 2'b00;
    reqB = 2'b00;
    reqWrite = 2'b00;
    reqAddr = '0;
    reqWdata = '0;
    reqBe = '0;
    waitrequest = 1'b0;
    readdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("resetStrobes", 64'({readA, writeA, readB, writeB}), 64'd0);
    checkOutput("resetBusy", 64'({busyA, busyB}), 64'd0);
    checkOutput("resetGrant", 64'({grantIdA, grantIdB}), 64'd0);
    checkOutput("resetRsp", 64'({rspValidA, rspValidB, rspErrA, rspErrB}), 64'd0);
    checkOutput("resetBusOut", 64'(addressA | writedataA | rspRdataA), 64'd0);
    is_reset = 1'b0;
    @(negedge clk);

    $display("[TB] single read, port 0, unaligned address");
    applyStimulus(0, 1'b0, 32'h0000_1003, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 1'b0);
    $display("[TB] write from port 1 with three waitrequest cycles");
    applyStimulus(1, 1'b1, 32'h0000_2006, 32'h1234_5678, 4'b0011, 3, 32'h0BAD_0BAD, 1'b0);
    $display("[TB] round-robin contention");
    runContention(1'b0, 1'b1);
    $display("[TB] timeout on stuck waitrequest, then clean read");
    applyStimulus(0, 1'b0, 32'h0000_3000, 32'h0, 4'hF, 0, 32'hAAAA_5555, 1'b1);
    applyStimulus(0, 1'b0, 32'h0000_3004, 32'h0, 4'h0, 0, 32'h0C0F_FEE0, 1'b0);
    $display("[TB] fixed-priority contention");
    runContention(1'b1, 1'b0);

    $display("[TB] asynchronous reset during BUS");
    reqWrite = 2'b00;
    reqAddr[32 +: 32] = 32'h0000_4000;
    waitrequest = 1'b1;
    reqA = 2'b10;
    @(negedge clk);
    checkOutput("preResetRead", 64'(readA), 64'd1);
    checkOutput("preResetGrant", 64'(grantIdA), 64'd1);
    #2 is_reset = 1'b1;
    #1;
    checkOutput("asyncResetRead", 64'(readA), 64'd0);
    checkOutput("asyncResetBusy", 64'(busyA), 64'd0);
    checkOutput("asyncResetGrant", 64'(grantIdA), 64'd0);
    reqA = 2'b00;
    repeat (2) @(negedge clk);
    is_reset = 1'b0;
    waitrequest = 1'b0;
    @(negedge clk);
    applyStimulus(1, 1'b0, 32'h0000_5008, 32'h0, 4'hF, 0, 32'h1357_2468, 1'b0);

    repeat (5) @(negedge clk);
    checkOutput("pendingA", 64'(expQA.size()), 64'd0);
    checkOutput("pendingB", 64'(expQB.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/avalon_mem_arbiter.md
Name: avalon_mem_arbiter

Overview:
Parametrised Avalon-MM bus master that lets NUM_PORTS CPU-side requesters share one memory bus, for example instruction fetch and load/store. It arbitrates between requesters and issues one transaction at a time on the bus. It honours waitrequest, aborts stalled accesses after a programmable timeout, and returns read data and status to the requester that was granted. It sits between the CPU core and the external Avalon memory, in place of a direct single-port connection.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, bus data width; multiple of 8; BE_W = DATA_W/8.
NUM_PORTS, 2, number of requesters (1..8); ID_W = max(1, clog2(NUM_PORTS)).
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin.
TIMEOUT_CYCLES, 0, maximum waitrequest-high cycles in BUS before abort; 0 disables the timeout.

Ports:
clk  in  1  clock.
is_reset  in  1  asynchronous, active-high reset.
req  in  NUM_PORTS  per-port request level.
req_write  in  NUM_PORTS  1 = write, 0 = read.
req_addr  in  NUM_PORTS*ADDR_W  byte address; port p occupies bits [p*ADDR_W +: ADDR_W].
req_wdata  in  NUM_PORTS*DATA_W  write data, flattened the same way.
req_byteenable  in  NUM_PORTS*BE_W  byte lanes, flattened the same way.
rsp_valid  out  NUM_PORTS  one-cycle completion pulse to the granted port.
rsp_err  out  1  qualifies rsp_valid; 1 = timed out.
rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
busy  out  1  high when state is not IDLE.
grant_id  out  ID_W  index of the port being served.
address  out  ADDR_W  Avalon address.
read  out  1  Avalon read strobe.
write  out  1  Avalon write strobe.
writedata  out  DATA_W  Avalon write data.
byteenable  out  BE_W  Avalon byte enables.
waitrequest  in  1  Avalon stall.
readdata  in  DATA_W  Avalon read data.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - State = IDLE.
  - All outputs = 0, including read, write, rsp_valid, busy and grant_id.
  - Round-robin pointer = 0; timeout counter = 0.
- All outputs are registered.
- States: IDLE, BUS, RESP.
- IDLE, when any req bit is high at a clk edge:
  - Select winner g. ARB_MODE=0: lowest set index. ARB_MODE=1: first set index at or after the pointer, wrapping modulo NUM_PORTS.
  - Latch g, write flag, address, wdata and byteenable for port g.
  - Next state BUS; busy=1; grant_id=g.
- IDLE with no req: remain in IDLE; all strobes low.
- BUS:
  - Assert read or write; address, writedata and byteenable are held stable.
  - address is the latched address with its low clog2(BE_W) bits forced to 0.
  - Strobes first rise one cycle after the edge that sampled req.
- BUS, edge with waitrequest=0 (completion):
  - Read: capture readdata into rsp_rdata. Write: rsp_rdata = 0.
  - Drop read/write at the same edge.
  - Next state RESP.
- BUS, edge with waitrequest=1:
  - Increment the timeout counter.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: drop the strobes, set rsp_err=1 and rsp_rdata=0, next state RESP.
- RESP:
  - rsp_valid[g]=1 for exactly one cycle; rsp_err is valid in the same cycle.
  - Clear the timeout counter.
  - Round robin: pointer = (g+1) mod NUM_PORTS.
  - Next state IDLE. req is not sampled in RESP.
- Minimum transaction: 3 cycles (IDLE, BUS, RESP). Each extra waitrequest-high cycle adds 1 cycle.
- Requester contract: hold req and its payload stable until rsp_valid.
  - If req drops while the port is in BUS, the bus access still completes and rsp_valid still pulses.
  - If req is still high in the cycle after rsp_valid, that is a new request.
- byteenable = 0 is issued to the bus as-is; no special case.
- NUM_PORTS=1: arbitration logic is degenerate; grant_id is constant 0.
- rsp_err is cleared on the next RESP without error. It is meaningful only while rsp_valid is high.

Test Plan:
1. Single read, port 0, addr 0x1003, waitrequest=0, readdata=0xDEADBEEF -> read high for 1 cycle at address 0x1000; rsp_valid[0] pulses 2 cycles after read rises with rsp_rdata=0xDEADBEEF and rsp_err=0.
2. Write from port 1, wdata 0x12345678, be 4'b0011, waitrequest held high 3 cycles -> write, writedata and byteenable stable for 4 cycles; rsp_valid[1] pulses once afterwards.
3. ARB_MODE=0, both ports requesting continuously -> port 0 is served every transaction and port 1 never; grant_id stays 0.
4. ARB_MODE=1, both ports requesting continuously -> grant_id alternates 0,1,0,1; each port receives rsp_valid every 6 cycles.
5. TIMEOUT_CYCLES=4, waitrequest stuck high -> read drops after 4 stalled cycles; rsp_valid[0]=1 with rsp_err=1 and rsp_rdata=0; the next transaction with waitrequest=0 returns rsp_err=0.
6. is_reset asserted mid-BUS with read=1 -> read, busy and grant_id go to 0 immediately without waiting for clk; no rsp_valid pulses; after release the first request issues normally.
